// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - parametrised universal shift register with FSM-controlled burst shifting
// Optional macro USR_ROTATE_EN adds a rotate input that recirculates the outgoing bit on shifts.
module universal_shift_reg #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
`ifdef USR_ROTATE_EN
   input  logic             rotate,
`endif
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] din,
   input  logic             sin_l,
   input  logic             sin_r,
   input  logic             start,
   input  logic [CNT_W-1:0] shamt,
   output logic [WIDTH-1:0] dout,
   output logic             sout_r,
   output logic             sout_l,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0]       MODE_HOLD = 2'b00;
   localparam logic [1:0]       MODE_SHR  = 2'b01;
   localparam logic [1:0]       MODE_SHL  = 2'b10;
   localparam logic [1:0]       MODE_LOAD = 2'b11;
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             done_q, done_d;
   logic             rot_sel;
   logic [CNT_W-1:0] shamt_sat;
   logic [WIDTH-1:0] shr_val, shl_val;

`ifdef USR_ROTATE_EN
   logic rot_q, rot_d;
   // A burst keeps the rotate setting captured at its start edge.
   assign rot_sel = (state_q == SHIFT) ? rot_q : rotate;
`else
   assign rot_sel = 1'b0;
`endif

   assign shamt_sat = (shamt > CNT_MAX) ? CNT_MAX : shamt;
   assign shr_val   = {(rot_sel ? q_q[0] : sin_l), q_q[WIDTH-1:1]};
   assign shl_val   = {q_q[WIDTH-2:0], (rot_sel ? q_q[WIDTH-1] : sin_r)};

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      done_d  = 1'b0;
`ifdef USR_ROTATE_EN
      rot_d   = rot_q;
`endif
      case (state_q)
         IDLE: begin
            if (start && (mode == MODE_SHR || mode == MODE_SHL)) begin
               dir_d = (mode == MODE_SHL);
               cnt_d = shamt_sat;
`ifdef USR_ROTATE_EN
               rot_d = rotate;
`endif
               if (shamt_sat != '0) state_d = SHIFT;
               else                 done_d  = 1'b1;
            end else begin
               case (mode)
                  MODE_SHR:  q_d = shr_val;
                  MODE_SHL:  q_d = shl_val;
                  MODE_LOAD: q_d = din;
                  MODE_HOLD: q_d = q_q;
                  default:   q_d = q_q;
               endcase
            end
         end
         SHIFT: begin
            q_d   = dir_q ? shl_val : shr_val;
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         q_q     <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         done_q  <= 1'b0;
`ifdef USR_ROTATE_EN
         rot_q   <= 1'b0;
`endif
      end else if (en) begin
         state_q <= state_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         done_q  <= done_d;
`ifdef USR_ROTATE_EN
         rot_q   <= rot_d;
`endif
      end
   end

   assign dout   = q_q;
   assign sout_r = q_q[0];
   assign sout_l = q_q[WIDTH-1];
   assign busy   = (state_q == SHIFT);
   assign done   = done_q;

endmodule
